// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int SRAM_LATENCY   = 5;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_OBUF_DEPTH = 8;

  // Width of a counter that must hold 0..entries inclusive.
  function automatic int credit_w(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Circular register FIFO that captures SRAM read returns and presents a valid/ready pop port.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int OBUF_DEPTH = DEF_OBUF_DEPTH,
  localparam int IW        = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1,
  localparam int CW        = credit_w(OBUF_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_data_o,
  input  logic             pop_rdy_i,
  output logic [CW-1:0]    cnt_o
);

  localparam logic [CW-1:0] LIM  = CW'(OBUF_DEPTH);
  localparam logic [IW-1:0] LAST = IW'(OBUF_DEPTH - 1);

  logic [WIDTH-1:0] mem [OBUF_DEPTH];
  logic [IW-1:0]    wr_idx, rd_idx;
  logic [CW-1:0]    cnt;
  logic             pop, wr;

  // Indices wrap explicitly so OBUF_DEPTH need not be a power of two.
  function automatic logic [IW-1:0] bump(input logic [IW-1:0] idx);
    return (idx == LAST) ? '0 : idx + IW'(1);
  endfunction

  assign pop        = (cnt != '0) && pop_rdy_i;
  assign wr         = wr_vld_i && ((cnt != LIM) || pop);
  assign pop_vld_o  = (cnt != '0);
  assign pop_data_o = mem[rd_idx];
  assign cnt_o      = cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (wr)  wr_idx <= bump(wr_idx);
      if (pop) rd_idx <= bump(rd_idx);
      case ({wr, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage has no reset; cnt gates pop_vld_o so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_idx] <= wr_data_i;
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a fixed-latency dual-port SRAM, with credit-limited read
// prefetch into a register output buffer. Define SRAM_FIFO_ERR_EN to add the sticky err_o flag.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int LATENCY    = SRAM_LATENCY,
  parameter int OBUF_DEPTH = DEF_OBUF_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  output logic              full_o,
  output logic              pop_vld_o,
  output logic [WIDTH-1:0]  pop_data_o,
  input  logic              pop_rdy_i,
  output logic              sram_wen_o,
  output logic [ADDR_W-1:0] sram_waddr_o,
  output logic [WIDTH-1:0]  sram_wdata_o,
  output logic              sram_ren_o,
  output logic [ADDR_W-1:0] sram_raddr_o,
  input  logic [WIDTH-1:0]  sram_rdata_i,
`ifdef SRAM_FIFO_ERR_EN
  output logic              err_o,
`endif
  input  logic              sram_vld_i
);

  localparam int CW = credit_w(OBUF_DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CW:0]     CREDITS  = (CW + 1)'(OBUF_DEPTH);

  if (OBUF_DEPTH < 2 || LATENCY < 1) begin : g_cfg_check
    $error("sram_fifo_ctrl: OBUF_DEPTH must be >= 2 and LATENCY >= 1");
  end

  logic [ADDR_W:0] wr_ptr, rd_ptr, sram_cnt;
  logic [CW-1:0]   inflight, inflight_nxt, obuf_cnt;
  logic [CW:0]     credit_used;
  logic            push_ok;

  assign sram_cnt    = wr_ptr - rd_ptr;
  assign credit_used = {1'b0, inflight} + {1'b0, obuf_cnt};
  assign full_o      = (sram_cnt == FULL_CNT);
  assign push_ok     = push_i && !full_o;

  assign sram_wen_o   = push_ok;
  assign sram_waddr_o = wr_ptr[ADDR_W-1:0];
  assign sram_wdata_o = push_data_i;

  // A read is issued only when its return is guaranteed a slot in the output buffer.
  assign sram_ren_o   = (sram_cnt != '0) && (credit_used < CREDITS);
  assign sram_raddr_o = rd_ptr[ADDR_W-1:0];

  always_comb begin
    // NOTE: default first so every path assigns inflight_nxt; a missing branch would infer a latch.
    inflight_nxt = inflight;
    case ({sram_ren_o, sram_vld_i})
      2'b10:   inflight_nxt = inflight + CW'(1);
      2'b01:   inflight_nxt = inflight - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      // NOTE: non-blocking so every register here updates from pre-edge values.
      if (push_ok)    wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
      if (sram_ren_o) rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
      inflight <= inflight_nxt;
    end
  end

  sram_fifo_obuf #(
    .WIDTH      (WIDTH),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_vld_i   (sram_vld_i),
    .wr_data_i  (sram_rdata_i),
    .pop_vld_o  (pop_vld_o),
    .pop_data_o (pop_data_o),
    .pop_rdy_i  (pop_rdy_i),
    .cnt_o      (obuf_cnt)
  );

`ifdef SRAM_FIFO_ERR_EN
  logic obuf_full, pop_fire;

  assign obuf_full = (obuf_cnt == CREDITS[CW-1:0]);
  assign pop_fire  = pop_vld_o && pop_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if ((push_i && full_o) ||
                 (sram_vld_i && (inflight == '0)) ||
                 (sram_vld_i && obuf_full && !pop_fire)) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a 5-cycle SRAM model and an ordering scoreboard.
module tb_sram_fifo_ctrl;

  localparam int W   = 8;
  localparam int D   = 8;
  localparam int AW  = 3;
  localparam int LAT = 5;
  localparam int OD  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [W-1:0]  push_data;
  logic          full;
  logic          pop_vld;
  logic [W-1:0]  pop_data;
  logic          pop_rdy;
  logic          sram_wen;
  logic [AW-1:0] sram_waddr;
  logic [W-1:0]  sram_wdata;
  logic          sram_ren;
  logic [AW-1:0] sram_raddr;
  logic [W-1:0]  sram_rdata;
  logic          sram_vld;
`ifdef SRAM_FIFO_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  sram_fifo_ctrl #(
    .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .LATENCY(LAT), .OBUF_DEPTH(OD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .push_data_i  (push_data),
    .full_o       (full),
    .pop_vld_o    (pop_vld),
    .pop_data_o   (pop_data),
    .pop_rdy_i    (pop_rdy),
    .sram_wen_o   (sram_wen),
    .sram_waddr_o (sram_waddr),
    .sram_wdata_o (sram_wdata),
    .sram_ren_o   (sram_ren),
    .sram_raddr_o (sram_raddr),
    .sram_rdata_i (sram_rdata),
`ifdef SRAM_FIFO_ERR_EN
    .err_o        (err),
`endif
    .sram_vld_i   (sram_vld)
  );

  // SRAM model: write at the edge, read data and valid emerge LAT cycles after ren.
  logic [W-1:0]   sram_mem [D];
  logic [LAT-1:0] pv;
  logic [W-1:0]   pd [LAT];

  always @(posedge clk) begin
    if (sram_wen) sram_mem[sram_waddr] <= sram_wdata;
    if (rst) pv <= '0;
    else     pv <= {pv[LAT-2:0], sram_ren};
    pd[0] <= sram_mem[sram_raddr];
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end

  assign sram_vld   = pv[LAT-1];
  assign sram_rdata = pd[LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard / model state
  logic [W-1:0] q [$];
  int cyc_n, pop_n, first_pop, last_pop, n_acc, n_rd;
  bit saw_full;
  logic s_wen, s_ren, s_pvld, s_full, s_err;
  logic [W-1:0] s_pdata;

  task automatic sb_reset();
    q.delete();
    cyc_n = 0; pop_n = 0; first_pop = -1; last_pop = -1;
    n_acc = 0; n_rd = 0; saw_full = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; push_data = '0; pop_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_reset();
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, run model checks, advance past the edge.
  task automatic cyc(input logic p, input logic [W-1:0] d, input logic r);
    logic [W-1:0] exp_d;
    push = p; push_data = d; pop_rdy = r;
    @(negedge clk);
    s_wen = sram_wen; s_ren = sram_ren; s_pvld = pop_vld; s_pdata = pop_data; s_full = full;
`ifdef SRAM_FIFO_ERR_EN
    s_err = err;
`else
    s_err = 1'b0;
`endif
    if (full) saw_full = 1'b1;
    check("wen_accept", {31'b0, sram_wen}, {31'b0, p && !full});
    if (q.size() < D) check("full_early", {31'b0, full}, 32'd0);
    check("credit_le_obuf", {31'b0, (int'(dut.inflight) + int'(dut.obuf_cnt)) <= OD}, 32'd1);
    if (sram_ren) begin
      check("ren_has_data", {31'b0, n_rd < n_acc}, 32'd1);
      check("raddr", {29'b0, sram_raddr}, 32'(n_rd % D));
      n_rd++;
    end
    if (sram_wen) begin
      check("waddr", {29'b0, sram_waddr}, 32'(n_acc % D));
      check("wdata", {24'b0, sram_wdata}, {24'b0, d});
      q.push_back(d);
      n_acc++;
    end
    if (pop_vld && r) begin
      check("pop_nonempty", {31'b0, q.size() > 1 || (q.size() == 1 && !sram_wen)}, 32'd1);
      if (q.size() != 0) begin
        exp_d = q.pop_front();
        check("pop_data", {24'b0, pop_data}, {24'b0, exp_d});
      end
      if (first_pop < 0) first_pop = cyc_n;
      last_pop = cyc_n;
      pop_n++;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         push;
    logic [W-1:0] data;
    logic         rdy;
    logic         wen;
    logic         ren;
    logic         pvld;
    logic [W-1:0] pdata;
    logic         full;
  } vec_t;

  vec_t vec [20];

  initial begin
    int guard;

    for (int i = 0; i < 20; i++) vec[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    // single push: write cycle 0, read issue cycle 1, pop_vld cycle 7, gone cycle 8
    vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    // two back-to-back pushes at cycles 10 and 11
    vec[10] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[11] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vec[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0};

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_pop_vld", {31'b0, pop_vld}, 32'd0);
    check("rst_wen", {31'b0, sram_wen}, 32'd0);
    check("rst_ren", {31'b0, sram_ren}, 32'd0);
`ifdef SRAM_FIFO_ERR_EN
    check("rst_err", {31'b0, err}, 32'd0);
`endif
    @(posedge clk);
    #1;

    // table-driven single/double push timing
    for (int i = 0; i < 20; i++) begin
      cyc(vec[i].push, vec[i].data, vec[i].rdy);
      check($sformatf("v%0d_wen", i), {31'b0, s_wen}, {31'b0, vec[i].wen});
      check($sformatf("v%0d_ren", i), {31'b0, s_ren}, {31'b0, vec[i].ren});
      check($sformatf("v%0d_pvld", i), {31'b0, s_pvld}, {31'b0, vec[i].pvld});
      check($sformatf("v%0d_full", i), {31'b0, s_full}, {31'b0, vec[i].full});
      if (vec[i].pvld) check($sformatf("v%0d_pdata", i), {24'b0, s_pdata}, {24'b0, vec[i].pdata});
    end

    // streaming 0..63 with consumer always ready
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, W'(i), 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    check("stream_first_pop", 32'(first_pop), 32'd7);
    check("stream_last_pop", 32'(last_pop), 32'd70);
    check("stream_pop_n", 32'(pop_n), 32'd64);
    check("stream_no_full", {31'b0, saw_full}, 32'd0);

    // capacity: 16 entries fill SRAM plus output buffer, 17th is dropped
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, W'(i), 1'b0);
    check("cap_full_lag", {31'b0, s_full}, 32'd0);
    cyc(1'b1, 8'hEE, 1'b0);
    check("cap_drop_wen", {31'b0, s_wen}, 32'd0);
    check("cap_full", {31'b0, s_full}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
`ifdef SRAM_FIFO_ERR_EN
    check("err_set", {31'b0, s_err}, 32'd1);
`endif
    repeat (4) cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b1);
    check("cap_pop_n", 32'(pop_n), 32'd16);
    check("cap_empty", 32'(q.size()), 32'd0);
`ifdef SRAM_FIFO_ERR_EN
    check("err_sticky", {31'b0, s_err}, 32'd1);
`endif

    // random backpressure, 1000 accepted pushes
    do_reset();
    guard = 0;
    while (n_acc < 1000 && guard < 20000) begin
      cyc($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 55);
      guard++;
    end
    check("rand_accepted", 32'(n_acc), 32'd1000);
    guard = 0;
    while (q.size() != 0 && guard < 300) begin
      cyc(1'b0, 8'h00, 1'b1);
      guard++;
    end
    check("rand_drained", 32'(q.size()), 32'd0);
    check("rand_pop_n", 32'(pop_n), 32'(n_acc));

    // reset three cycles after reads start
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(i + 1), 1'b0);
    rst = 1'b1; push = 1'b0; pop_rdy = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_reset();
    @(negedge clk);
    check("mid_rst_full", {31'b0, full}, 32'd0);
    check("mid_rst_pop_vld", {31'b0, pop_vld}, 32'd0);
    check("mid_rst_wen", {31'b0, sram_wen}, 32'd0);
    check("mid_rst_ren", {31'b0, sram_ren}, 32'd0);
`ifdef SRAM_FIFO_ERR_EN
    check("mid_rst_err", {31'b0, err}, 32'd0);
`endif
    @(posedge clk);
    #1;
    cyc(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1);
    check("mid_rst_first_pop", 32'(first_pop), 32'd7);
    check("mid_rst_pop_n", 32'(pop_n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
